// File: rtl/sd_resp_rx_if.sv
// ----------------------------------------------------------------------------
// sd_resp_rx_if
//   Signal bundle between the host-controller FSM and the SD CMD-line
//   response receiver.
//
//   Signals:
//     start        host -> rx  single-cycle arm request
//     skip_crc     host -> rx  sampled with start; 1 = R3 (no CRC check)
//     cmd_in       host -> rx  synchronized CMD line, idles high
//     busy         rx -> host  waiting for start bit or receiving
//     done         rx -> host  one-cycle completion / timeout pulse
//     resp_index   rx -> host  response bits 45:40
//     resp_arg     rx -> host  response bits 39:8
//     crc_error    rx -> host  CRC7 mismatch (or CRC field != 7'h7F for R3)
//     frame_error  rx -> host  bad transmission bit or end bit
//     timeout      rx -> host  no start bit inside the Ncr window
//
//   Modports:
//     master  host-controller side
//     slave   receiver side
// ----------------------------------------------------------------------------
interface sd_resp_rx_if;
    logic        start;
    logic        skip_crc;
    logic        cmd_in;
    logic        busy;
    logic        done;
    logic [5:0]  resp_index;
    logic [31:0] resp_arg;
    logic        crc_error;
    logic        frame_error;
    logic        timeout;

    modport master (
        output start, skip_crc, cmd_in,
        input  busy, done, resp_index, resp_arg, crc_error, frame_error, timeout
    );

    modport slave (
        input  start, skip_crc, cmd_in,
        output busy, done, resp_index, resp_arg, crc_error, frame_error, timeout
    );
endinterface

// File: rtl/sd_resp_rx.sv
// ----------------------------------------------------------------------------
// sd_resp_rx
//   Bit-serial receiver for 48-bit SD command responses (R1/R1b/R3/R6/R7).
//   Once armed it waits up to TIMEOUT cycles for the start bit, shifts in
//   one CMD bit per clock, runs CRC7 (x^7 + x^3 + 1) over bits 47..8 and
//   checks the received CRC field and the framing bits.
//
//   Parameters:
//     TIMEOUT  Ncr limit in clk cycles spent waiting for the start bit.
//
//   Ports:
//     clk    sampling clock, one CMD bit per rising edge
//     reset  synchronous, active-high; aborts any transfer without done
//     bus    sd_resp_rx_if.slave (handshake, CMD line and results)
// ----------------------------------------------------------------------------
module sd_resp_rx #(
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          reset,
    sd_resp_rx_if.slave   bus
);

    localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_START,
        RECV,
        DONE
    } state_e;

    state_e            state_q,       state_d;
    logic [WAIT_W-1:0] wait_cnt_q,    wait_cnt_d;
    logic [5:0]        bit_cnt_q,     bit_cnt_d;
    logic [6:0]        crc_q,         crc_d;
    logic [6:0]        rx_crc_q,      rx_crc_d;
    logic              skip_crc_q,    skip_crc_d;
    logic [5:0]        resp_index_q,  resp_index_d;
    logic [31:0]       resp_arg_q,    resp_arg_d;
    logic              crc_error_q,   crc_error_d;
    logic              frame_error_q, frame_error_d;
    logic              timeout_q,     timeout_d;

    // One step of the serial CRC7 shift register.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every _d holds its _q value unless a branch below overrides
        // it, so no path through the case can leave a latch behind.
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        crc_d         = crc_q;
        rx_crc_d      = rx_crc_q;
        skip_crc_d    = skip_crc_q;
        resp_index_d  = resp_index_q;
        resp_arg_d    = resp_arg_q;
        crc_error_d   = crc_error_q;
        frame_error_d = frame_error_q;
        timeout_d     = timeout_q;

        unique case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                crc_d      = 7'h00;
                if (bus.start) begin
                    // Results of the previous response are held until here.
                    state_d       = WAIT_START;
                    skip_crc_d    = bus.skip_crc;
                    rx_crc_d      = 7'h00;
                    resp_index_d  = '0;
                    resp_arg_d    = '0;
                    crc_error_d   = 1'b0;
                    frame_error_d = 1'b0;
                    timeout_d     = 1'b0;
                end
            end

            WAIT_START: begin
                if (!bus.cmd_in) begin
                    // Start bit is response bit 47 and is part of the CRC.
                    // Checked first so a start bit in the last wait cycle
                    // wins over the timeout.
                    state_d   = RECV;
                    crc_d     = crc7_step(crc_q, bus.cmd_in);
                    bit_cnt_d = 6'd46;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end

            RECV: begin
                if (bit_cnt_q >= 6'd8) begin
                    crc_d = crc7_step(crc_q, bus.cmd_in);
                end

                if (bit_cnt_q == 6'd46 && bus.cmd_in) begin
                    frame_error_d = 1'b1;
                end

                if (bit_cnt_q >= 6'd40 && bit_cnt_q <= 6'd45) begin
                    resp_index_d = {resp_index_q[4:0], bus.cmd_in};
                end

                if (bit_cnt_q >= 6'd8 && bit_cnt_q <= 6'd39) begin
                    resp_arg_d = {resp_arg_q[30:0], bus.cmd_in};
                end

                if (bit_cnt_q >= 6'd1 && bit_cnt_q <= 6'd7) begin
                    rx_crc_d = {rx_crc_q[5:0], bus.cmd_in};
                end

                if (bit_cnt_q == 6'd0) begin
                    // End bit. Both CRCs are complete by now, so the compare
                    // is registered here and is already valid in the DONE
                    // cycle alongside the done pulse.
                    if (!bus.cmd_in) begin
                        frame_error_d = 1'b1;
                    end
                    crc_error_d = skip_crc_q ? (rx_crc_q != 7'h7F)
                                             : (rx_crc_q != crc_q);
                    state_d     = DONE;
                end else begin
                    bit_cnt_d = bit_cnt_q - 1'b1;
                end
            end

            DONE: begin
                // start is deliberately not looked at here.
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments make every register sample the
        // pre-edge values, independent of statement order.
        if (reset) begin
            state_q       <= IDLE;
            wait_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            crc_q         <= '0;
            rx_crc_q      <= '0;
            skip_crc_q    <= 1'b0;
            resp_index_q  <= '0;
            resp_arg_q    <= '0;
            crc_error_q   <= 1'b0;
            frame_error_q <= 1'b0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            crc_q         <= crc_d;
            rx_crc_q      <= rx_crc_d;
            skip_crc_q    <= skip_crc_d;
            resp_index_q  <= resp_index_d;
            resp_arg_q    <= resp_arg_d;
            crc_error_q   <= crc_error_d;
            frame_error_q <= frame_error_d;
            timeout_q     <= timeout_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.busy        = (state_q == WAIT_START) || (state_q == RECV);
    assign bus.done        = (state_q == DONE);
    assign bus.resp_index  = resp_index_q;
    assign bus.resp_arg    = resp_arg_q;
    assign bus.crc_error   = crc_error_q;
    assign bus.frame_error = frame_error_q;
    assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_sd_resp_rx.sv
// ----------------------------------------------------------------------------
// tb_sd_resp_rx
//   Directed testbench for sd_resp_rx with TIMEOUT = 64. Inputs change 1 ns
//   after each rising edge and outputs are sampled at the same point, so every
//   value observed reflects the state after the preceding edge.
// ----------------------------------------------------------------------------
module tb_sd_resp_rx;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    bit   early_done;

    sd_resp_rx_if bus ();

    sd_resp_rx #(
        .TIMEOUT(64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one edge; busy must be visible right after that edge.
    task automatic arm(input logic skip);
        bus.start    = 1'b1;
        bus.skip_crc = skip;
        early_done   = 1'b0;
        tick();
        bus.start    = 1'b0;
        bus.skip_crc = 1'b0;
        check("arm_busy", 48'(bus.busy), 48'd1);
    endtask

    task automatic idle(input int n);
        bus.cmd_in = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (bus.done) early_done = 1'b1;
        end
    endtask

    // Drive a full 48-bit frame MSB first. The start bit is sampled at edge
    // S, the end bit at edge S+47, so done must be high right after that edge
    // and never before. With poke set, start/skip_crc pulse mid-frame.
    task automatic send_frame(input logic [47:0] f, input bit poke);
        for (int i = 47; i >= 0; i--) begin
            bus.cmd_in   = f[i];
            bus.start    = poke && (i == 30 || i == 10);
            bus.skip_crc = poke;
            tick();
            if (i != 0 && bus.done) early_done = 1'b1;
        end
        bus.start    = 1'b0;
        bus.skip_crc = 1'b0;
        bus.cmd_in   = 1'b1;
        check("no_early_done", 48'(early_done), 48'd0);
        check("done_pulse", 48'(bus.done), 48'd1);
        check("busy_low_at_done", 48'(bus.busy), 48'd0);
    endtask

    task automatic check_result(input string tag, input logic [5:0] idx,
                                input logic [31:0] arg, input logic crc_e,
                                input logic frm_e, input logic to);
        check({tag, "_index"},  48'(bus.resp_index),  48'(idx));
        check({tag, "_arg"},    48'(bus.resp_arg),    48'(arg));
        check({tag, "_crc"},    48'(bus.crc_error),   48'(crc_e));
        check({tag, "_frame"},  48'(bus.frame_error), 48'(frm_e));
        check({tag, "_timeout"},48'(bus.timeout),     48'(to));
    endtask

    initial begin
        int n;
        logic [47:0] f;

        tests        = 0;
        fails        = 0;
        early_done   = 1'b0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.skip_crc = 1'b0;
        bus.cmd_in   = 1'b1;

        // Reset state
        tick();
        tick();
        check("rst_busy", 48'(bus.busy), 48'd0);
        check("rst_done", 48'(bus.done), 48'd0);
        check_result("rst", 6'h00, 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();

        // CMD55 R1 after 5 idle-high cycles
        arm(1'b0);
        idle(5);
        send_frame(48'h37_0000_0120_83, 1'b0);
        check_result("cmd55", 6'h37, 32'h0000_0120, 1'b0, 1'b0, 1'b0);
        tick();
        check("done_one_cycle", 48'(bus.done), 48'd0);
        check("hold_index", 48'(bus.resp_index), 48'h37);
        check("hold_arg", 48'(bus.resp_arg), 48'h120);

        // CMD8 R7; start/skip_crc pulses during RECV must be ignored
        arm(1'b0);
        idle(2);
        send_frame(48'h08_0000_01AA_13, 1'b1);
        check_result("cmd8", 6'h08, 32'h0000_01AA, 1'b0, 1'b0, 1'b0);

        // start during DONE is ignored; start in the next cycle is accepted
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("start_in_done_ignored", 48'(bus.busy), 48'd0);
        arm(1'b0);
        check("clear_on_start_index", 48'(bus.resp_index), 48'd0);
        check("clear_on_start_arg", 48'(bus.resp_arg), 48'd0);

        // CMD55 with argument bit 0 flipped -> CRC error only
        idle(1);
        send_frame(48'h37_0000_0121_83, 1'b0);
        check_result("arg_flip", 6'h37, 32'h0000_0121, 1'b1, 1'b0, 1'b0);
        tick();

        // CMD55 with end bit 0 -> frame error only
        arm(1'b0);
        idle(1);
        send_frame(48'h37_0000_0120_82, 1'b0);
        check_result("end_bit", 6'h37, 32'h0000_0120, 1'b0, 1'b1, 1'b0);
        tick();

        // R3 with skip_crc=1: CRC field 7F accepted
        arm(1'b1);
        idle(3);
        send_frame(48'h3F_00FF_8000_FF, 1'b0);
        check_result("r3_skip", 6'h3F, 32'h00FF_8000, 1'b0, 1'b0, 1'b0);
        tick();

        // Same R3 frame with skip_crc=0 -> CRC error
        arm(1'b0);
        idle(3);
        send_frame(48'h3F_00FF_8000_FF, 1'b0);
        check_result("r3_noskip", 6'h3F, 32'h00FF_8000, 1'b1, 1'b0, 1'b0);
        tick();

        // Timeout: count edges from the arming edge (inclusive) until done
        arm(1'b0);
        bus.cmd_in = 1'b1;
        n = 1;
        while (!bus.done && n < 200) begin
            tick();
            n++;
        end
        check("timeout_latency", 48'(n), 48'd65);
        check_result("timeout", 6'h00, 32'h0, 1'b0, 1'b0, 1'b1);
        tick();

        // Start bit in the last wait cycle (counter 63) -> normal receive
        arm(1'b0);
        idle(63);
        send_frame(48'h37_0000_0120_83, 1'b0);
        check_result("late_start", 6'h37, 32'h0000_0120, 1'b0, 1'b0, 1'b0);
        tick();

        // Reset at bit 20 of a frame aborts with no done
        arm(1'b0);
        idle(2);
        f = 48'h37_0000_0120_83;
        for (int i = 47; i > 20; i--) begin
            bus.cmd_in = f[i];
            tick();
        end
        bus.cmd_in = f[20];
        reset      = 1'b1;
        tick();
        check("midrst_busy", 48'(bus.busy), 48'd0);
        check("midrst_done", 48'(bus.done), 48'd0);
        check_result("midrst", 6'h00, 32'h0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        early_done = 1'b0;
        for (int i = 19; i >= 0; i--) begin
            bus.cmd_in = f[i];
            tick();
            if (bus.done || bus.busy) early_done = 1'b1;
        end
        bus.cmd_in = 1'b1;
        check("midrst_stays_idle", 48'(early_done), 48'd0);

        // Fresh frame after reset
        arm(1'b0);
        idle(4);
        send_frame(48'h08_0000_01AA_13, 1'b0);
        check_result("after_rst", 6'h08, 32'h0000_01AA, 1'b0, 1'b0, 1'b0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sd_resp_rx.md
# sd_resp_rx

Bit-serial receiver for SD-card command responses on the CMD line. It runs in the same clock domain as the command CRC7 generator and the CMD-line transmitter. When armed, it waits for the card's start bit and deserializes a 48-bit response (R1/R1b/R3/R6/R7 format). While shifting, it computes CRC7 (G(x) = x^7 + x^3 + 1) over the first 40 bits, then checks it against the received CRC and validates the framing bits. It reports index, argument and error flags to the host-controller FSM.

## Interface
- TIMEOUT, default 64: Ncr limit. Maximum number of clk cycles spent waiting for the start bit after arming.
- clk  input  1: sampling clock; one CMD bit per rising edge.
- reset  input  1: synchronous, active-high; returns the block to IDLE.
- start  input  1: single-cycle arm request; ignored unless in IDLE.
- skip_crc  input  1: sampled with start; 1 = R3 response (CRC field must be 7'b1111111, no CRC check).
- cmd_in  input  1: CMD line, already synchronized; idles high.
- busy  output  1: high in WAIT_START and RECV.
- done  output  1: one-cycle pulse when a response completes or times out.
- resp_index  output  6: response bits 45:40.
- resp_arg  output  32: response bits 39:8.
- crc_error  output  1: received CRC ≠ computed CRC (or ≠ 7'h7F when skip_crc).
- frame_error  output  1: transmission bit (46) ≠ 0 or end bit (0) ≠ 1.
- timeout  output  1: no start bit within TIMEOUT cycles.

## Operation
- States: IDLE, WAIT_START, RECV, DONE.
- IDLE:
  - start=1 → WAIT_START.
  - Latch skip_crc; clear crc_error, frame_error, timeout, resp_index, resp_arg.
  - Clear the wait counter and the CRC register (7'h00).
- WAIT_START:
  - cmd_in=0 → RECV. This bit is bit 47 and is fed into the CRC; the bit counter is set to 46.
  - Otherwise the wait counter increments. When it reaches TIMEOUT-1 with cmd_in still 1 → DONE with timeout=1.
- RECV: one bit per cycle, bits 46 down to 0.
  - Bits 47..8: serial CRC update each bit.
    - fb = cmd_in ^ crc[6].
    - crc ← {crc[5:0],1'b0} ^ (fb ? 7'h09 : 7'h00).
  - Bit 46: record frame_error if it is 1.
  - Bits 45:40 → resp_index; bits 39:8 → resp_arg. Both are shifted in MSB first.
  - Bits 7..1: shift into a received-CRC register.
  - Bit 0: this is the end bit. Record frame_error if it is 0, then → DONE.
- DONE:
  - Lasts one cycle with done=1; crc_error is resolved here.
  - Then → IDLE.
  - All result outputs hold their values until the next accepted start.
- start outside IDLE has no effect. This includes start during DONE; the request must be re-issued in IDLE.
- The bit counter is 6 bits and decrements without wrap. RECV exits on count 0 only.

## Timing
- Reset values: busy=0, done=0, resp_index=0, resp_arg=0, crc_error=0, frame_error=0, timeout=0, state=IDLE.
- Reset in any state, including mid-frame, aborts with no done pulse.
- start sampled in cycle T → busy=1 from T+1.
- Start bit sampled in cycle S. The end bit is sampled in S+47; done=1 in S+48; busy=0 from S+48.
- Timeout: start in T, cmd_in held high → done=1, timeout=1 in T+1+TIMEOUT.
- A start bit sampled in the final wait cycle (counter = TIMEOUT-1) is accepted; the receive takes priority over timeout.
- The minimum IDLE gap between done and the next accepted start is 1 cycle: start may be asserted the cycle after done.

## Test plan
- CMD55 R1 response 0x37_0000_0120_83 after 5 idle-high cycles → done at start-bit cycle +48; resp_index=6'h37; resp_arg=32'h00000120; crc_error=0; frame_error=0; timeout=0.
- CMD8 R7 response 0x08_0000_01AA_13 → resp_index=6'h08; resp_arg=32'h000001AA; no errors.
- Same CMD55 frame with arg bit 0 flipped (0x37_0000_0121_83) → crc_error=1, frame_error=0. Also with end bit 0 (last byte 0x82) → frame_error=1.
- R3 frame 0x3F_00FF_8000_FF with skip_crc=1 → resp_index=6'h3F; resp_arg=32'h00FF8000; crc_error=0. The same frame with skip_crc=0 → crc_error=1.
- Timeout, TIMEOUT=64: start, cmd_in stuck high → done with timeout=1 exactly 65 cycles after start. A start bit in wait cycle 63 → normal receive, timeout=0.
- Reset asserted at bit 20 of a frame → all outputs zero next cycle, no done. start pulses during busy are ignored. A fresh frame after reset decodes correctly.
